// File: rtl/clock_calendar.sv
// clock_calendar: BCD month/day/hour/minute/second timekeeper with button set mode,
//   presenting mode char + 10 digit chars as an 88-bit ASCII bus for the LCD driver.
// Latency: button event 3 cycles after press; `value` registered one cycle after fields.
// Backpressure: none; free-running, the LCD driver samples `value` whenever it likes.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   btn_mode   debounced level button, advances RUN->SET_MONTH->SET_DAY->SET_HOUR->SET_MIN->RUN
//   btn_inc    debounced level button, increments the selected field in a SET state
//   value      {mode, mon10, mon1, day10, day1, hr10, hr1, min10, min1, sec10, sec1} ASCII
//   tick_1hz   one-cycle pulse on each elapsed second (RUN only)
//   set_active high in any SET state
module clock_calendar #(
   parameter int TICK_DIV = 50000000,
   parameter int CNT_W    = 26
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_mode,
   input  logic        btn_inc,
   output logic [87:0] value,
   output logic        tick_1hz,
   output logic        set_active
);

   typedef enum logic [2:0] {
      RUN       = 3'd0,
      SET_MONTH = 3'd1,
      SET_DAY   = 3'd2,
      SET_HOUR  = 3'd3,
      SET_MIN   = 3'd4
   } state_t;

   localparam logic [87:0] VALUE_RST = 88'h20_30_31_30_31_30_30_30_30_30_30;

   // BCD +1 on a two-nibble field; callers handle the field's own wrap point.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Days in month, BCD in and out; no year field so February is always 28.
   function automatic logic [7:0] dim(input logic [7:0] m);
      case (m)
         8'h02:                      return 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
         default:                    return 8'h31;
      endcase
   endfunction

   function automatic logic [7:0] asc(input logic [3:0] n);
      return {4'h3, n};
   endfunction

   state_t         state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]     mon_q, mon_d, day_q, day_d, hour_q, hour_d;
   logic [7:0]     min_q, min_d, sec_q, sec_d;
   logic [7:0]     mon_n;
   logic           tick_q, tick_d;
   logic           set_q;
   logic [87:0]    value_q;
   logic [2:0]     mode_sync_q, inc_sync_q;
   logic           mode_evt, inc_evt;

   // [1:0] is the two-flop synchronizer, [2] the previous synchronized level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_sync_q <= 3'b000;
         inc_sync_q  <= 3'b000;
      end else begin
         mode_sync_q <= {mode_sync_q[1:0], btn_mode};
         inc_sync_q  <= {inc_sync_q[1:0], btn_inc};
      end
   end

   assign mode_evt = mode_sync_q[1] & ~mode_sync_q[2];
   assign inc_evt  = inc_sync_q[1] & ~inc_sync_q[2];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mon_d   = mon_q;
      day_d   = day_q;
      hour_d  = hour_q;
      min_d   = min_q;
      sec_d   = sec_q;
      tick_d  = 1'b0;
      mon_n   = (mon_q == 8'h12) ? 8'h01 : bcd_inc(mon_q);
      case (state_q)
         RUN: begin
            // A mode press on the wrap cycle takes priority and swallows the tick.
            if (mode_evt) begin
               state_d = SET_MONTH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
               cnt_d  = '0;
               tick_d = 1'b1;
               if (sec_q == 8'h59) begin
                  sec_d = 8'h00;
                  if (min_q == 8'h59) begin
                     min_d = 8'h00;
                     if (hour_q == 8'h23) begin
                        hour_d = 8'h00;
                        if (day_q == dim(mon_q)) begin
                           day_d = 8'h01;
                           mon_d = mon_n;
                        end else begin
                           day_d = bcd_inc(day_q);
                        end
                     end else begin
                        hour_d = bcd_inc(hour_q);
                     end
                  end else begin
                     min_d = bcd_inc(min_q);
                  end
               end else begin
                  sec_d = bcd_inc(sec_q);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SET_MONTH: begin
            cnt_d = '0;
            if (mode_evt) begin
               state_d = SET_DAY;
            end else if (inc_evt) begin
               mon_d = mon_n;
               // Keep the date valid when moving to a shorter month.
               if (day_q > dim(mon_n)) day_d = dim(mon_n);
            end
         end
         SET_DAY: begin
            cnt_d = '0;
            if (mode_evt)     state_d = SET_HOUR;
            else if (inc_evt) day_d = (day_q == dim(mon_q)) ? 8'h01 : bcd_inc(day_q);
         end
         SET_HOUR: begin
            cnt_d = '0;
            if (mode_evt)     state_d = SET_MIN;
            else if (inc_evt) hour_d = (hour_q == 8'h23) ? 8'h00 : bcd_inc(hour_q);
         end
         SET_MIN: begin
            cnt_d = '0;
            if (mode_evt) begin
               // Leaving set mode starts a fresh second from :00.
               state_d = RUN;
               sec_d   = 8'h00;
            end else if (inc_evt) begin
               min_d = (min_q == 8'h59) ? 8'h00 : bcd_inc(min_q);
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
         mon_q   <= 8'h01;
         day_q   <= 8'h01;
         hour_q  <= 8'h00;
         min_q   <= 8'h00;
         sec_q   <= 8'h00;
         tick_q  <= 1'b0;
         set_q   <= 1'b0;
         value_q <= VALUE_RST;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mon_q   <= mon_d;
         day_q   <= day_d;
         hour_q  <= hour_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         tick_q  <= tick_d;
         set_q   <= (state_d != RUN);
         // Built from the stored fields in one register so all characters move together.
         value_q <= {(state_q == RUN) ? 8'h20 : 8'h53,
                     asc(mon_q[7:4]),  asc(mon_q[3:0]),
                     asc(day_q[7:4]),  asc(day_q[3:0]),
                     asc(hour_q[7:4]), asc(hour_q[3:0]),
                     asc(min_q[7:4]),  asc(min_q[3:0]),
                     asc(sec_q[7:4]),  asc(sec_q[3:0])};
      end
   end

   assign value      = value_q;
   assign tick_1hz   = tick_q;
   assign set_active = set_q;

endmodule

// File: tb/tb_clock_calendar.sv
// tb_clock_calendar: self-checking bench for clock_calendar with TICK_DIV=10.
// Latency: button presses take 6 cycles each; checks sample on the falling edge.
// Backpressure: not applicable.
module tb_clock_calendar;

   localparam logic [87:0] RESET_VAL = 88'h20_30_31_30_31_30_30_30_30_30_30;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        btn_mode = 1'b0;
   logic        btn_inc = 1'b0;
   logic [87:0] value;
   logic        tick_1hz;
   logic        set_active;

   int n_chk  = 0;
   int n_fail = 0;
   logic [87:0] exp_q[$];

   typedef struct {
      int mo, dy, hr, mi;
      int emo, edy, ehr, emi, ese;
   } vec_t;
   vec_t vecs[5];

   always #5 clk = ~clk;

   clock_calendar #(.TICK_DIV(10), .CNT_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_mode   (btn_mode),
      .btn_inc    (btn_inc),
      .value      (value),
      .tick_1hz   (tick_1hz),
      .set_active (set_active)
   );

   function automatic logic [87:0] mk_val(input bit s, input int mo, input int dy,
                                          input int hr, input int mi, input int se);
      logic [87:0] v;
      v[87:80] = s ? 8'h53 : 8'h20;
      v[79:72] = 8'h30 + 8'(mo / 10);
      v[71:64] = 8'h30 + 8'(mo % 10);
      v[63:56] = 8'h30 + 8'(dy / 10);
      v[55:48] = 8'h30 + 8'(dy % 10);
      v[47:40] = 8'h30 + 8'(hr / 10);
      v[39:32] = 8'h30 + 8'(hr % 10);
      v[31:24] = 8'h30 + 8'(mi / 10);
      v[23:16] = 8'h30 + 8'(mi % 10);
      v[15:8]  = 8'h30 + 8'(se / 10);
      v[7:0]   = 8'h30 + 8'(se % 10);
      return v;
   endfunction

   task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_pop(input string name);
      logic [87:0] e;
      if (exp_q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = exp_q.pop_front();
         chk(name, value, e);
      end
   endtask

   // which: 0 = mode, 1 = inc, 2 = both together
   task automatic press(input int which);
      @(negedge clk);
      btn_mode = (which != 1);
      btn_inc  = (which != 0);
      repeat (2) @(negedge clk);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_tick(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (tick_1hz) seen = 1'b1;
      end
      if (!seen) begin
         n_chk++;
         n_fail++;
         $display("FAIL tick_timeout: no tick_1hz within %0d cycles", budget);
      end
   endtask

   // Starting from the reset date 01-01 00:00:00, dial in a date/time; seconds end at 00.
   task automatic set_time(input int mo, input int dy, input int hr, input int mi);
      press(0);
      repeat (mo - 1) press(1);
      press(0);
      repeat (dy - 1) press(1);
      press(0);
      repeat (hr) press(1);
      press(0);
      repeat (mi) press(1);
      press(0);
   endtask

   initial begin : main
      int    cnt, last, first;
      bit    gaps_ok, seen;
      logic [87:0] snap;

      vecs[0] = '{12, 31, 23, 59,  1,  1,  0, 0, 0};
      vecs[1] = '{ 2, 28, 23, 59,  3,  1,  0, 0, 0};
      vecs[2] = '{ 4, 30, 23, 59,  5,  1,  0, 0, 0};
      vecs[3] = '{ 6, 15,  9, 59,  6, 15, 10, 0, 0};
      vecs[4] = '{11, 30, 23, 59, 12,  1,  0, 0, 0};

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset value", value, RESET_VAL);
      chk("reset tick", tick_1hz, 1'b0);
      chk("reset set_active", set_active, 1'b0);

      // Free run: 10 ticks in 100 cycles, 10 apart
      rst_n = 1'b1;
      cnt = 0; last = 0; gaps_ok = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (tick_1hz) begin
            if (k - last != 10) gaps_ok = 1'b0;
            last = k;
            cnt++;
         end
      end
      chk("run tick count", 88'(cnt), 88'd10);
      chk("run tick spacing", gaps_ok, 1'b1);
      @(negedge clk);
      chk("run 10 seconds", value, mk_val(0, 1, 1, 0, 0, 10));

      // Carry-chain vectors: set, run to :59, then one more tick
      for (int i = 0; i < 5; i++) begin
         do_reset();
         set_time(vecs[i].mo, vecs[i].dy, vecs[i].hr, vecs[i].mi);
         repeat (59) wait_tick(20);
         exp_q.push_back(mk_val(0, vecs[i].mo, vecs[i].dy, vecs[i].hr, vecs[i].mi, 59));
         exp_q.push_back(mk_val(0, vecs[i].emo, vecs[i].edy, vecs[i].ehr, vecs[i].emi,
                                vecs[i].ese));
         wait_tick(20);
         chk_pop($sformatf("vec%0d pre-tick", i));
         @(negedge clk);
         chk_pop($sformatf("vec%0d post-tick", i));
      end

      // Set mode, freeze, clamp, exit timing
      do_reset();
      set_time(1, 31, 10, 20);
      repeat (33) wait_tick(20);
      press(0);
      chk("set enter value", value, mk_val(1, 1, 31, 10, 20, 33));
      chk("set enter active", set_active, 1'b1);
      snap = value;
      seen = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (tick_1hz) seen = 1'b1;
      end
      chk("set frozen value", value, snap);
      chk("set no tick", seen, 1'b0);
      press(1);
      chk("month clamp", value, mk_val(1, 2, 28, 10, 20, 33));
      repeat (3) press(0);
      @(negedge clk);
      btn_mode = 1'b1;
      first = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 2) btn_mode = 1'b0;
         if (tick_1hz && first == 0) first = k;
         if (k == 5) begin
            chk("exit value", value, mk_val(0, 2, 28, 10, 20, 0));
            chk("exit active", set_active, 1'b0);
         end
      end
      chk("exit first tick", 88'(first), 88'd13);

      // Simultaneous mode+inc, hour/minute wraps, held inc
      do_reset();
      press(0);
      press(2);
      chk("mode beats inc", value, mk_val(1, 1, 1, 0, 0, 0));
      press(1);
      chk("day inc", value, mk_val(1, 1, 2, 0, 0, 0));
      press(0);
      repeat (23) press(1);
      chk("hour 23", value, mk_val(1, 1, 2, 23, 0, 0));
      press(1);
      chk("hour wrap", value, mk_val(1, 1, 2, 0, 0, 0));
      press(0);
      repeat (59) press(1);
      chk("min 59", value, mk_val(1, 1, 2, 0, 59, 0));
      press(1);
      chk("min wrap", value, mk_val(1, 1, 2, 0, 0, 0));
      @(negedge clk);
      btn_inc = 1'b1;
      repeat (20) @(negedge clk);
      btn_inc = 1'b0;
      repeat (4) @(negedge clk);
      chk("held inc once", value, mk_val(1, 1, 2, 0, 1, 0));

      // Mode event lands on the tick cycle
      do_reset();
      seen = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (tick_1hz) seen = 1'b1;
      end
      btn_mode = 1'b1;
      for (int k = 8; k <= 25; k++) begin
         @(negedge clk);
         if (k == 9) btn_mode = 1'b0;
         if (tick_1hz) seen = 1'b1;
      end
      chk("collision no tick", seen, 1'b0);
      chk("collision value", value, mk_val(1, 1, 1, 0, 0, 0));
      chk("collision active", set_active, 1'b1);

      // Asynchronous reset in SET_DAY
      press(0);
      press(1);
      chk("set_day value", value, mk_val(1, 1, 2, 0, 0, 0));
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset value", value, RESET_VAL);
      chk("async reset active", set_active, 1'b0);
      chk("async reset tick", tick_1hz, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
